i2c_write_master: RTL and testbench

//  Drives the I2C side of the SPI-to-I2C bridge. Consumes bytes from the SPI slave's

---
 rtl/i2c_pkg.sv | 35 +++
 rtl/i2c_phase_gen.sv | 46 ++++
 rtl/i2c_write_master.sv | 172 +++++++++++++++++
 tb/tb_i2c_write_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C write master: FSM state codes, quarter indices
// and the per-state SCL/SDA drive table.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_ADDR_ACK = 3'd3;
    localparam logic [2:0] ST_DATA     = 3'd4;
    localparam logic [2:0] ST_DATA_ACK = 3'd5;
    localparam logic [2:0] ST_STOP     = 3'd6;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BIT_CNT_W = 3;

    // Returns {scl, sda_oe} for one quarter of one slot; data_bit is the bit on the wire.
    function automatic logic [1:0] bus_levels(input logic [2:0] state,
                                              input logic [1:0] quarter,
                                              input logic       data_bit);
        logic scl_hi;
        scl_hi = (quarter == Q2) || (quarter == Q3);
        case (state)
            ST_START:                 bus_levels = {1'b1, scl_hi};
            ST_ADDR, ST_DATA:         bus_levels = {scl_hi, ~data_bit};
            ST_ADDR_ACK, ST_DATA_ACK: bus_levels = {scl_hi, 1'b0};
            ST_STOP:                  bus_levels = {quarter != Q0, (quarter == Q0) || (quarter == Q1)};
            default:                  bus_levels = 2'b10;
        endcase
    endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-period timebase: DIV-cycle divider plus a 2-bit quarter index, held
// at zero while disabled so every transfer starts on q0.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    output logic       tick_o,
    output logic       slot_end_o,
    output logic [1:0] quarter_o,
    output logic [1:0] quarter_d_o
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       quarter_q, quarter_d;

    assign tick_o      = en_i && (cnt_q == CNT_W'(DIV - 1));
    assign slot_end_o  = tick_o && (quarter_q == Q3);
    assign quarter_o   = quarter_q;
    assign quarter_d_o = quarter_d;

    always_comb begin
        cnt_d     = '0;
        quarter_d = Q0;
        if (en_i) begin
            cnt_d     = tick_o ? '0 : cnt_q + 1'b1;
            quarter_d = tick_o ? quarter_q + 2'd1 : quarter_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q     <= '0;
            quarter_q <= Q0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

// File: rtl/i2c_write_master.sv
// One I2C write (START, addr+W, ACK, data, ACK, STOP) per byte from the SPI side,
// with a one-entry hold register in front of the shift register.
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DIV        = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             ack_err_o,
    output logic             overflow_o,
    output logic             scl_o,
    output logic             sda_oe_o,
    input  logic             sda_i
);

    localparam logic [WIDTH-1:0] ADDR_BYTE = WIDTH'({SLAVE_ADDR, 1'b0});

    logic [2:0]           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 ack_bit_q, ack_bit_d;
    logic                 ack_err_q, ack_err_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;
    logic                 scl_q, scl_d;
    logic                 sda_oe_q, sda_oe_d;

    logic       tick, slot_end, sample, start;
    logic [1:0] quarter, quarter_d;

    i2c_phase_gen #(.DIV(DIV)) u_phase (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (state_q != ST_IDLE),
        .tick_o     (tick),
        .slot_end_o (slot_end),
        .quarter_o  (quarter),
        .quarter_d_o(quarter_d)
    );

    assign sample = tick && (quarter == Q2);
    assign start  = (state_q == ST_IDLE) && hold_full_q;

    assign ready_o    = !hold_full_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign ack_err_o  = ack_err_q;
    assign overflow_o = ovf_q;
    assign scl_o      = scl_q;
    assign sda_oe_o   = sda_oe_q;

    // A strobe in the same cycle the hold register drains into START is kept.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_q;
        if (start) hold_full_d = 1'b0;
        if (data_valid_i) begin
            if (!hold_full_q || start) begin
                hold_d      = data_i;
                hold_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ack_bit_d = ack_bit_q;
        ack_err_d = ack_err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_START;
                    data_d    = hold_q;
                    shift_d   = ADDR_BYTE;
                    ack_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = '0;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (slot_end) begin
                    shift_d = shift_q << 1;
                    if (bit_cnt_q == BIT_CNT_W'(WIDTH - 1)) begin
                        state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (sample) ack_bit_d = sda_i;
                if (slot_end) begin
                    if (ack_bit_q) begin
                        ack_err_d = 1'b1;
                        state_d   = ST_STOP;
                    end else begin
                        state_d   = ST_DATA;
                        shift_d   = data_q;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA_ACK: begin
                if (sample) ack_bit_d = sda_i;
                if (slot_end) begin
                    if (ack_bit_q) ack_err_d = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (slot_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus pins are registered from next-state values so they line up with state_q.
    assign done_d = (state_q == ST_STOP) && slot_end;
    assign {scl_d, sda_oe_d} = bus_levels(state_d, quarter_d, shift_d[WIDTH-1]);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ack_bit_q   <= 1'b0;
            ack_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ack_bit_q   <= ack_bit_d;
            ack_err_q   <= ack_err_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a transaction-level waveform model predicts every
// output each cycle, plus directed checks on bits, timing, overflow and reset.
module tb_i2c_write_master;

    localparam int         DIV   = 4;
    localparam logic [6:0] SADDR = 7'h50;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       ready_o, busy_o, done_o, ack_err_o, overflow_o, scl_o, sda_oe_o;
    logic       sda_i;

    always #5 clk_i = ~clk_i;

    i2c_write_master #(.WIDTH(8), .SLAVE_ADDR(SADDR), .DIV(DIV)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .data_i      (data_i),
        .data_valid_i(data_valid_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ack_err_o   (ack_err_o),
        .overflow_o  (overflow_o),
        .scl_o       (scl_o),
        .sda_oe_o    (sda_oe_o),
        .sda_i       (sda_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: per-cycle expected waveform of each transfer
    logic [3:0] wave_q[$];   // {slave_pull, scl, sda_oe, ack_err}
    logic [1:0] resp_q[$];   // {addr_nack, data_nack} per upcoming transfer
    logic       h_full = 1'b0, ovf_s = 1'b0, ack_s = 1'b0;
    logic [7:0] h_byte = 8'h00;
    logic m_scl = 1'b1, m_oe = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic m_ack = 1'b0, m_ovf = 1'b0, m_ready = 1'b1, m_pull = 1'b0;

    assign sda_i = !(sda_oe_o || m_pull);

    function automatic logic [3:0] slot_entry(input int s, input int q, input logic [7:0] db,
                                              input logic an, input logic dn, input int last);
        logic [7:0] ab;
        logic hi;
        ab = {SADDR, 1'b0};
        hi = (q >= 2);
        if (s == 0)         slot_entry = {1'b0, 1'b1, hi, 1'b0};
        else if (s == last) slot_entry = {1'b0, q != 0, q < 2, an || dn};
        else if (s <= 8)    slot_entry = {1'b0, hi, !ab[8-s], 1'b0};
        else if (s == 9)    slot_entry = {!an, hi, 1'b0, 1'b0};
        else if (s <= 17)   slot_entry = {1'b0, hi, !db[17-s], 1'b0};
        else                slot_entry = {!dn, hi, 1'b0, 1'b0};
    endfunction

    always @(posedge clk_i) begin : model_blk
        logic [3:0] e;
        logic [1:0] r;
        logic       nb, fr;
        int         last;
        if (!reset_i) begin
            wave_q.delete();
            h_full = 1'b0; ovf_s = 1'b0; ack_s = 1'b0;
            m_scl <= 1'b1; m_oe <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
            m_ack <= 1'b0; m_ovf <= 1'b0; m_ready <= 1'b1; m_pull <= 1'b0;
        end else begin
            fr = !m_busy && h_full;
            if (fr) begin
                r = 2'b00;
                if (resp_q.size() > 0) r = resp_q.pop_front();
                last = r[1] ? 10 : 19;
                for (int s = 0; s <= last; s++)
                    for (int q = 0; q < 4; q++)
                        for (int c = 0; c < DIV; c++)
                            wave_q.push_back(slot_entry(s, q, h_byte, r[1], r[0], last));
                ack_s  = r[1] || r[0];
                h_full = 1'b0;
            end
            if (data_valid_i) begin
                if (!h_full) begin
                    h_byte = data_i;
                    h_full = 1'b1;
                end else begin
                    ovf_s = 1'b1;
                end
            end
            if (wave_q.size() > 0) begin
                e  = wave_q.pop_front();
                nb = 1'b1;
            end else begin
                e  = {1'b0, 1'b1, 1'b0, ack_s};
                nb = 1'b0;
            end
            m_done  <= m_busy && !nb;
            m_busy  <= nb;
            m_pull  <= e[3];
            m_scl   <= e[2];
            m_oe    <= e[1];
            m_ack   <= e[0];
            m_ovf   <= ovf_s;
            m_ready <= !h_full;
        end
    end

    // ---------------- compare process
    logic chk_en = 1'b0;
    always @(negedge clk_i) begin
        if (chk_en && reset_i) begin
            check("scl_o", scl_o, m_scl);
            check("sda_oe_o", sda_oe_o, m_oe);
            check("busy_o", busy_o, m_busy);
            check("done_o", done_o, m_done);
            check("ack_err_o", ack_err_o, m_ack);
            check("overflow_o", overflow_o, m_ovf);
            check("ready_o", ready_o, m_ready);
        end
    end

    // ---------------- bus monitor: SDA bits at SCL rise, run lengths, START/STOP edges
    logic mon_en = 1'b0;
    logic prev_scl = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0;
    logic rise_q[$];
    int low_len = 0, long_lows = 0, short_lows = 0, odd_lows = 0;
    int start_edges = 0, stop_edges = 0, scl_edges = 0;
    int busy_len = 0, last_busy_len = 0, done_cnt = 0;

    always @(negedge clk_i) begin
        if (mon_en && reset_i) begin
            if (scl_o != prev_scl) scl_edges++;
            if (scl_o && !prev_scl) begin
                rise_q.push_back(sda_i);
                if (low_len == 2 * DIV)  long_lows++;
                else if (low_len == DIV) short_lows++;
                else                     odd_lows++;
                low_len = 0;
            end
            if (!scl_o) low_len++;
            if (scl_o && prev_scl && sda_oe_o && !prev_oe) start_edges++;
            if (scl_o && prev_scl && !sda_oe_o && prev_oe) stop_edges++;
            if (busy_o) busy_len++;
            if (!busy_o && prev_busy) begin
                last_busy_len = busy_len;
                busy_len = 0;
            end
            if (done_o) done_cnt++;
        end
        prev_scl  = scl_o;
        prev_oe   = sda_oe_o;
        prev_busy = busy_o;
    end

    function automatic logic [7:0] rise_byte(input int base);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], rise_q[base+i]};
        return b;
    endfunction

    // ---------------- driver tasks
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i); #1;
        data_i = b;
        data_valid_i = 1'b1;
        @(posedge clk_i); #1;
        data_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!done_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check(nm, done_o, 1'b1);
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!busy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check(nm, busy_o, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence
    initial begin : main
        int d0;
        repeat (3) @(negedge clk_i);
        check("rst_scl", scl_o, 1'b1);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_ack_err", ack_err_o, 1'b0);
        check("rst_overflow", overflow_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        mon_en = 1'b1;

        // T1: 0xA5 acked end to end
        resp_q.push_back(2'b00);
        rise_q.delete();
        send_byte(8'hA5);
        wait_done("t1_done");
        #1;
        check("t1_busy_cycles", last_busy_len, 80 * DIV);
        check("t1_rise_count", rise_q.size(), 19);
        check("t1_addr_byte", rise_byte(0), 8'hA0);
        check("t1_addr_ack", rise_q[8], 1'b0);
        check("t1_data_byte", rise_byte(9), 8'hA5);
        check("t1_ack_err", ack_err_o, 1'b0);

        // T2: address NACK, data phase skipped
        resp_q.push_back(2'b10);
        rise_q.delete();
        send_byte(8'h11);
        wait_done("t2_done");
        #1;
        check("t2_busy_cycles", last_busy_len, 44 * DIV);
        check("t2_rise_count", rise_q.size(), 10);
        check("t2_addr_nack", rise_q[8], 1'b1);
        check("t2_ack_err", ack_err_o, 1'b1);

        // T3: strobe mid-transfer, then a strobe on the cycle the hold register drains
        repeat (3) resp_q.push_back(2'b00);
        rise_q.delete();
        send_byte(8'h81);
        repeat (50) @(negedge clk_i);
        check("t3_ready_mid", ready_o, 1'b1);
        send_byte(8'h3C);
        wait_done("t3_done1");
        data_i = 8'h7E;
        data_valid_i = 1'b1;
        check("t3_data1", rise_byte(9), 8'h81);
        rise_q.delete();
        @(posedge clk_i); #1;
        data_valid_i = 1'b0;
        @(negedge clk_i);
        check("t3_restart", busy_o, 1'b1);
        check("t3_hold_refilled", ready_o, 1'b0);
        check("t3_ack_err_cleared", ack_err_o, 1'b0);
        wait_done("t3_done2");
        #1;
        check("t3_data2", rise_byte(9), 8'h3C);
        check("t3_overflow", overflow_o, 1'b0);
        rise_q.delete();
        wait_done("t3_done3");
        #1;
        check("t3_data3", rise_byte(9), 8'h7E);
        check("t3_overflow_end", overflow_o, 1'b0);

        // T4: third strobe while busy with hold full is dropped
        repeat (2) resp_q.push_back(2'b00);
        d0 = done_cnt;
        send_byte(8'h11);
        repeat (30) @(negedge clk_i);
        send_byte(8'h22);
        repeat (30) @(negedge clk_i);
        check("t4_hold_full", ready_o, 1'b0);
        send_byte(8'h33);
        @(negedge clk_i);
        check("t4_overflow", overflow_o, 1'b1);
        wait_done("t4_done1");
        #1;
        rise_q.delete();
        wait_done("t4_done2");
        #1;
        check("t4_data2", rise_byte(9), 8'h22);
        repeat (200) @(negedge clk_i);
        check("t4_transfers", done_cnt - d0, 2);
        check("t4_idle", busy_o, 1'b0);

        check("proto_long_lows", long_lows, 117);
        check("proto_short_lows", short_lows, 7);
        check("proto_odd_lows", odd_lows, 0);
        check("proto_start_edges", start_edges, 7);
        check("proto_stop_edges", stop_edges, 7);

        // T5: reset in the middle of DATA bit 3
        resp_q.push_back(2'b00);
        send_byte(8'h96);
        wait_busy("t5_busy");
        repeat (13 * 4 * DIV + DIV + 1) @(negedge clk_i);
        check("t5_pre_scl", scl_o, 1'b0);
        check("t5_pre_busy", busy_o, 1'b1);
        chk_en = 1'b0;
        #1;
        reset_i = 1'b0;
        #1;
        check("t5_scl", scl_o, 1'b1);
        check("t5_sda_oe", sda_oe_o, 1'b0);
        check("t5_busy", busy_o, 1'b0);
        check("t5_done", done_o, 1'b0);
        check("t5_ready", ready_o, 1'b1);
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        resp_q.delete();
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        scl_edges = 0;
        d0 = done_cnt;
        repeat (100) @(negedge clk_i);
        #1;
        check("t5_no_scl_edges", scl_edges, 0);
        check("t5_still_idle", busy_o, 1'b0);
        check("t5_no_done", done_cnt - d0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
